// File: rtl/alu_issue_arbiter_if.sv
// Issue-side and writeback-side handshake bundle for alu_issue_arbiter.
// The arbiter connects through the slave modport; the issue/writeback side uses the master modport.
interface alu_issue_arbiter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAGW  = 5
) ();
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_ctrl;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [TAGW-1:0]  req0_tag;

  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_ctrl;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [TAGW-1:0]  req1_tag;

  logic             res_valid;
  logic             res_ready;
  logic             res_slot;
  logic [TAGW-1:0]  res_tag;
  logic [WIDTH-1:0] res_data;
  logic             res_zero;
  logic             busy;

  modport slave (
    input  req0_valid, req0_ctrl, req0_a, req0_b, req0_tag,
    output req0_ready,
    input  req1_valid, req1_ctrl, req1_a, req1_b, req1_tag,
    output req1_ready,
    input  res_ready,
    output res_valid, res_slot, res_tag, res_data, res_zero, busy
  );

  modport master (
    output req0_valid, req0_ctrl, req0_a, req0_b, req0_tag,
    input  req0_ready,
    output req1_valid, req1_ctrl, req1_a, req1_b, req1_tag,
    input  req1_ready,
    output res_ready,
    input  res_valid, res_slot, res_tag, res_data, res_zero, busy
  );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Round-robin share of one ALU between two issue slots, with a one-entry result register.
// Optional macro ALU_ARB_STATS_EN adds saturating grant/conflict counters.
module alu_issue_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAGW  = 5
) (
  input logic                clk,
  input logic                rst,
  alu_issue_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]        stat_grant0,
  output logic [15:0]        stat_grant1,
  output logic [15:0]        stat_conflict
`endif
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e           state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic             res_slot_q;
  logic [TAGW-1:0]  res_tag_q;
  logic [WIDTH-1:0] res_data_q;

  logic             can_accept;
  logic             grant0, grant1;
  logic             accept;
  logic [3:0]       op_ctrl;
  logic [WIDTH-1:0] op_a, op_b;
  logic [TAGW-1:0]  op_tag;
  logic [WIDTH-1:0] alu_res;
  logic [31:0]      lui_val;

  assign can_accept = (state_q == StEmpty) | bus.res_ready;

  // Contested cycles follow rr_ptr; an uncontested valid always wins.
  assign grant1 = bus.req1_valid & (~bus.req0_valid | rr_ptr_q);
  assign grant0 = bus.req0_valid & ~grant1;

  assign bus.req0_ready = grant0 & can_accept & ~rst;
  assign bus.req1_ready = grant1 & can_accept & ~rst;
  assign accept         = bus.req0_ready | bus.req1_ready;

  assign op_ctrl = grant1 ? bus.req1_ctrl : bus.req0_ctrl;
  assign op_a    = grant1 ? bus.req1_a    : bus.req0_a;
  assign op_b    = grant1 ? bus.req1_b    : bus.req0_b;
  assign op_tag  = grant1 ? bus.req1_tag  : bus.req0_tag;
  assign lui_val = {op_b[15:0], 16'h0000};

  always_comb begin
    alu_res = '0;
    unique case (op_ctrl)
      4'b0000: alu_res = op_a & op_b;
      4'b0001: alu_res = op_a | op_b;
      4'b0010: alu_res = op_a + op_b;
      4'b0011: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'b0100: alu_res = op_a ^ op_b;
      4'b0101: alu_res = ~(op_a | op_b);
      4'b0110: alu_res = op_a - op_b;
      4'b0111: alu_res = WIDTH'(lui_val);
      4'b1000: alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = ~grant1;
    end
    unique case (state_q)
      StEmpty: if (accept) state_d = StFull;
      StFull:  if (!accept && bus.res_ready) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StEmpty;
      rr_ptr_q   <= 1'b0;
      res_slot_q <= 1'b0;
      res_tag_q  <= '0;
      res_data_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      if (accept) begin
        res_slot_q <= grant1;
        res_tag_q  <= op_tag;
        res_data_q <= alu_res;
      end
    end
  end

  assign bus.res_valid = (state_q == StFull);
  assign bus.res_slot  = res_slot_q;
  assign bus.res_tag   = res_tag_q;
  assign bus.res_data  = res_data_q;
  // Qualified by valid so the reset/empty value reads as not-zero.
  assign bus.res_zero  = (state_q == StFull) & (res_data_q == '0);
  assign bus.busy      = (state_q == StFull) & ~bus.res_ready;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] stat_grant0_q, stat_grant1_q, stat_conflict_q;
  logic        conflict;

  assign conflict = bus.req0_valid & bus.req1_valid & can_accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_grant0_q   <= '0;
      stat_grant1_q   <= '0;
      stat_conflict_q <= '0;
    end else begin
      if (bus.req0_ready && stat_grant0_q != 16'hFFFF) stat_grant0_q <= stat_grant0_q + 16'd1;
      if (bus.req1_ready && stat_grant1_q != 16'hFFFF) stat_grant1_q <= stat_grant1_q + 16'd1;
      if (conflict && stat_conflict_q != 16'hFFFF) stat_conflict_q <= stat_conflict_q + 16'd1;
    end
  end

  assign stat_grant0   = stat_grant0_q;
  assign stat_grant1   = stat_grant1_q;
  assign stat_conflict = stat_conflict_q;
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Scoreboard bench for alu_issue_arbiter: a reference arbiter/ALU model runs on the falling edge.
module tb_alu_issue_arbiter;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned TAGW  = 5;

  typedef struct packed {
    logic             slot;
    logic [TAGW-1:0]  tag;
    logic [WIDTH-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  alu_issue_arbiter_if #(.WIDTH(WIDTH), .TAGW(TAGW)) bus ();

`ifdef ALU_ARB_STATS_EN
  logic [15:0] stat_grant0, stat_grant1, stat_conflict;
  alu_issue_arbiter #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_conflict(stat_conflict)
  );
`else
  alu_issue_arbiter #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] alu_ref(input logic [3:0] c, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (c)
      4'h0: return a & b;
      4'h1: return a | b;
      4'h2: return a + b;
      4'h3: return ($signed(a) < $signed(b)) ? 1 : 0;
      4'h4: return a ^ b;
      4'h5: return ~(a | b);
      4'h6: return a - b;
      4'h7: return {b[15:0], 16'h0000};
      4'h8: return (a < b) ? 1 : 0;
      default: return '0;
    endcase
  endfunction

  // Reference model, evaluated at each falling edge for the coming rising edge.
  ent_t q[$];
  logic exp_valid = 1'b0;
  logic exp_rr = 1'b0;
  logic acc0 = 1'b0, acc1 = 1'b0;

  always @(negedge clk) begin
    logic can, g0, g1;
    ent_t e;
    if (rst) begin
      q.delete();
      exp_valid = 1'b0;
      exp_rr    = 1'b0;
      acc0      = 1'b0;
      acc1      = 1'b0;
      check("rst_valid", 64'(bus.res_valid), 64'd0);
      check("rst_slot", 64'(bus.res_slot), 64'd0);
      check("rst_tag", 64'(bus.res_tag), 64'd0);
      check("rst_data", 64'(bus.res_data), 64'd0);
      check("rst_zero", 64'(bus.res_zero), 64'd0);
      check("rst_ready", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
    end else begin
      can = ~exp_valid | bus.res_ready;
      g1  = bus.req1_valid & (~bus.req0_valid | exp_rr);
      g0  = bus.req0_valid & ~g1;
      acc0 = g0 & can;
      acc1 = g1 & can;
      check("ready0", 64'(bus.req0_ready), 64'(acc0));
      check("ready1", 64'(bus.req1_ready), 64'(acc1));
      check("res_valid", 64'(bus.res_valid), 64'(exp_valid));
      check("busy", 64'(bus.busy), 64'(exp_valid & ~bus.res_ready));
      if (exp_valid) begin
        e = q[0];
        check("res_slot", 64'(bus.res_slot), 64'(e.slot));
        check("res_tag", 64'(bus.res_tag), 64'(e.tag));
        check("res_data", 64'(bus.res_data), 64'(e.data));
        check("res_zero", 64'(bus.res_zero), 64'(e.data == '0));
        if (bus.res_ready) void'(q.pop_front());
      end
      if (acc0 | acc1) begin
        e.slot = acc1;
        e.tag  = acc1 ? bus.req1_tag : bus.req0_tag;
        e.data = acc1 ? alu_ref(bus.req1_ctrl, bus.req1_a, bus.req1_b)
                      : alu_ref(bus.req0_ctrl, bus.req0_a, bus.req0_b);
        q.push_back(e);
        exp_rr    = ~acc1;
        exp_valid = 1'b1;
      end else if (bus.res_ready) begin
        exp_valid = 1'b0;
      end
    end
  end

  task automatic set_req(input int s, input logic v, input logic [3:0] c,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [TAGW-1:0] t);
    if (s == 0) begin
      bus.req0_valid = v; bus.req0_ctrl = c; bus.req0_a = a; bus.req0_b = b; bus.req0_tag = t;
    end else begin
      bus.req1_valid = v; bus.req1_ctrl = c; bus.req1_a = a; bus.req1_b = b; bus.req1_tag = t;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0]       c;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] r;
  } op_t;

  op_t ops[8] = '{
    '{4'h6, 32'd3, 32'd5, 32'hFFFFFFFE},
    '{4'h3, 32'hFFFFFFFF, 32'd1, 32'd1},
    '{4'h8, 32'hFFFFFFFF, 32'd1, 32'd0},
    '{4'h7, 32'd0, 32'h1234, 32'h12340000},
    '{4'h5, 32'd0, 32'd0, 32'hFFFFFFFF},
    '{4'h4, 32'hA5, 32'hA5, 32'd0},
    '{4'hC, 32'h55, 32'h66, 32'd0},
    '{4'h1, 32'hF0, 32'h0F, 32'hFF}
  };

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_rdy[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    set_req(0, 1'b0, 4'h0, '0, '0, '0);
    set_req(1, 1'b0, 4'h0, '0, '0, '0);
    bus.res_ready = 1'b1;
    do_reset();

    // Single op
    step();
    set_req(0, 1'b1, 4'h2, 32'd5, 32'd7, 5'd3);
    #1 check("single_ready", 64'(bus.req0_ready), 64'd1);
    step();
    bus.req0_valid = 1'b0;
    check("single_valid", 64'(bus.res_valid), 64'd1);
    check("single_data", 64'(bus.res_data), 64'd12);
    check("single_tag", 64'(bus.res_tag), 64'd3);
    check("single_slot", 64'(bus.res_slot), 64'd0);
    check("single_zero", 64'(bus.res_zero), 64'd0);
    step();

    // Contention from reset
    do_reset();
    set_req(0, 1'b1, 4'h2, 32'd10, 32'd1, 5'd10);
    set_req(1, 1'b1, 4'h6, 32'd20, 32'd1, 5'd20);
    for (int i = 0; i < 4; i++) begin
      #1 check("cont_grant", 64'({bus.req1_ready, bus.req0_ready}), 64'(exp_rdy[i]));
      step();
    end
    set_req(0, 1'b0, 4'h0, '0, '0, '0);
    set_req(1, 1'b0, 4'h0, '0, '0, '0);
    step();

    // Directed ALU ops
    for (int i = 0; i < 8; i++) begin
      set_req(0, 1'b1, ops[i].c, ops[i].a, ops[i].b, 5'(i));
      step();
      bus.req0_valid = 1'b0;
      check("op_data", 64'(bus.res_data), 64'(ops[i].r));
      check("op_zero", 64'(bus.res_zero), 64'(ops[i].r == '0));
    end
    step();

    // Backpressure
    bus.res_ready = 1'b0;
    set_req(0, 1'b1, 4'h2, 32'd1, 32'd1, 5'd1);
    step();
    bus.req0_valid = 1'b0;
    set_req(1, 1'b1, 4'h6, 32'd9, 32'd4, 5'd2);
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_ready", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
      check("bp_data", 64'(bus.res_data), 64'd2);
      step();
    end
    bus.res_ready = 1'b1;
    #1 check("bp_drain_ready", 64'(bus.req1_ready), 64'd1);
    step();
    bus.req1_valid = 1'b0;
    check("bp_valid_kept", 64'(bus.res_valid), 64'd1);
    check("bp_new_slot", 64'(bus.res_slot), 64'd1);
    check("bp_new_data", 64'(bus.res_data), 64'd5);
    step();

    // Asynchronous reset while FULL
    bus.res_ready = 1'b0;
    set_req(0, 1'b1, 4'h0, 32'hFF, 32'h0F, 5'd7);
    step();
    set_req(1, 1'b1, 4'h1, 32'h1, 32'h2, 5'd8);
    #1 rst = 1'b1;
    #1 check("arst_valid", 64'(bus.res_valid), 64'd0);
    check("arst_ready", 64'({bus.req0_ready, bus.req1_ready}), 64'd0);
    step();
    rst = 1'b0;
    bus.res_ready = 1'b1;
    #1 check("arst_first_grant", 64'({bus.req1_ready, bus.req0_ready}), 64'b01);
    step();
    set_req(0, 1'b0, 4'h0, '0, '0, '0);
    set_req(1, 1'b0, 4'h0, '0, '0, '0);
    step();

    // Random traffic; held requests keep their fields until accepted
    for (int i = 0; i < 400; i++) begin
      if (!bus.req0_valid || acc0)
        set_req(0, 1'($urandom_range(0, 1)), 4'($urandom), $urandom_range(0, 3) == 0 ? '0 : $urandom,
                $urandom_range(0, 3) == 0 ? '0 : $urandom, 5'($urandom));
      if (!bus.req1_valid || acc1)
        set_req(1, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom, 5'($urandom));
      bus.res_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    set_req(0, 1'b0, 4'h0, '0, '0, '0);
    set_req(1, 1'b0, 4'h0, '0, '0, '0);
    bus.res_ready = 1'b1;
    repeat (3) step();

`ifdef ALU_ARB_STATS_EN
    do_reset();
    set_req(0, 1'b1, 4'h2, 32'd1, 32'd2, 5'd1);
    set_req(1, 1'b1, 4'h2, 32'd3, 32'd4, 5'd2);
    repeat (70000) step();
    set_req(0, 1'b0, 4'h0, '0, '0, '0);
    set_req(1, 1'b0, 4'h0, '0, '0, '0);
    step();
    check("stat_conflict", 64'(stat_conflict), 64'hFFFF);
    check("stat_grant0", 64'(stat_grant0), 64'd35000);
    check("stat_grant1", 64'(stat_grant1), 64'd35000);
`endif

    check("sb_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
